// File: rtl/demux_1to4_4bits_reg.sv
// Registered 1-to-4 demultiplexer with per-channel valid/ready holding registers.
// One input stream is steered to a channel chosen by S or by a round-robin
// pointer. A full channel that is being drained in the same cycle can accept
// a new word, so a single channel sustains one word per cycle.
module demux_1to4_4bits_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       S,
    input  logic             rr_mode,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Y0,
    output logic [WIDTH-1:0] Y1,
    output logic [WIDTH-1:0] Y2,
    output logic [WIDTH-1:0] Y3,
    output logic [3:0]       Y_valid,
    input  logic [3:0]       Y_ready,
    output logic [1:0]       rr_ptr
);

    logic [3:0][WIDTH-1:0] y_q;
    logic [3:0][WIDTH-1:0] y_d;
    logic [3:0]            valid_q;
    logic [3:0]            valid_d;
    logic [1:0]            rr_ptr_q;
    logic [1:0]            rr_ptr_d;

    logic [1:0]            dest_s;
    logic [3:0]            free_s;
    logic                  in_ready_s;
    logic                  accept_s;

    // Destination select and handshake: a channel is free when empty or being drained now.
    always_comb begin
        dest_s     = 2'd0;
        free_s     = 4'b0000;
        in_ready_s = 1'b0;
        accept_s   = 1'b0;
        if (rr_mode) begin
            dest_s = rr_ptr_q;
        end else begin
            dest_s = S;
        end
        free_s     = ~valid_q | Y_ready;
        in_ready_s = free_s[dest_s];
        accept_s   = in_valid & in_ready_s;
    end

    // Next-state for channel registers: load the destination, clear delivered channels.
    always_comb begin
        y_d     = y_q;
        valid_d = valid_q;
        for (int k = 0; k < 4; k++) begin
            if (accept_s && (dest_s == 2'(k))) begin
                y_d[k]     = D;
                valid_d[k] = 1'b1;
            end else if (valid_q[k] && Y_ready[k]) begin
                valid_d[k] = 1'b0;
            end else begin
                valid_d[k] = valid_q[k];
            end
        end
    end

    // Next-state for the round-robin pointer: advance only on an accept in rr mode.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept_s && rr_mode) begin
            rr_ptr_d = rr_ptr_q + 2'd1;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // State registers; reset discards all channel contents and rewinds the pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_q      <= '0;
            valid_q  <= 4'b0000;
            rr_ptr_q <= 2'b00;
        end else begin
            y_q      <= y_d;
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Output mapping; all outputs except in_ready come straight from flops.
    always_comb begin
        Y0       = y_q[0];
        Y1       = y_q[1];
        Y2       = y_q[2];
        Y3       = y_q[3];
        Y_valid  = valid_q;
        rr_ptr   = rr_ptr_q;
        in_ready = in_ready_s;
    end

endmodule

// File: doc/demux_1to4_4bits_reg.md
Name: demux_1to4_4bits_reg

Overview:
- Registered 1-to-4 demultiplexer for 4-bit data. It is the distributing counterpart of the 4-bit 4-to-1 select path.
- Takes one valid/ready input stream and steers each accepted word into one of four output holding registers, each with its own valid/ready handshake.
- Destination comes from an explicit 2-bit select or from an internal round-robin pointer.
- Used wherever a single producer feeds four consumers, e.g. distributing results to per-unit queues.

Parameters:
- WIDTH, 4, data width of D and of each Y output.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  D/S/rr_mode are presenting a word this cycle.
- in_ready  output  1  demux can accept the word this cycle.
- S  input  2  destination channel select (used when rr_mode=0).
- rr_mode  input  1  1: ignore S, destination = rr_ptr; 0: destination = S.
- D  input  WIDTH  input data word.
- Y0, Y1, Y2, Y3  output  WIDTH each  channel holding registers.
- Y_valid  output  4  bit k = Yk holds an undelivered word.
- Y_ready  input  4  bit k = consumer k takes Yk this cycle.
- rr_ptr  output  2  current round-robin destination.

Behaviour:
- Reset is asynchronous and active-low; clk and reset_n are the single clock and reset.
- While reset_n=0: Y0..Y3=0, Y_valid=4'b0000, rr_ptr=2'b00. Exit from reset takes effect on the first clk edge with reset_n=1.
- dest = rr_mode ? rr_ptr : S (combinational).
- free[k] = !Y_valid[k] || Y_ready[k]. Pass-through: a full channel being drained this cycle counts as free.
- in_ready = free[dest] (combinational from S, rr_mode, rr_ptr, Y_valid, Y_ready). in_ready does not depend on in_valid.
- accept = in_valid && in_ready.
- On accept at edge: Y[dest] <= D and Y_valid[dest] <= 1. This holds even if Y_ready[dest]=1, where the old word delivers and the new word loads in the same cycle.
- Any channel k not loaded this edge: if Y_valid[k] && Y_ready[k], then Y_valid[k] <= 0. Yk data holds its value; it is not cleared.
- Y_ready[k] while Y_valid[k]=0 has no effect.
- Latency: D appears on Y[dest] with Y_valid set one cycle after accept.
- Throughput: one word per cycle if the destination consumer keeps Y_ready high.
- The four channels drain independently and concurrently; a stall on one channel blocks input only when it is the current dest (head-of-line blocking, by design).
- rr_ptr advances +1 mod 4 (3 -> 0 wrap) on each accept with rr_mode=1 only. It holds on non-accept cycles and in rr_mode=0.
- rr_mode may change on any cycle and takes effect immediately. rr_ptr is retained across mode changes, not reset.
- in_valid=1 with in_ready=0: no state change. The producer must hold D/S stable until accepted.
- Data, S and rr_mode values while in_valid=0 are don't-care.
- reset_n asserted mid-operation: all channel contents are discarded immediately; rr_ptr=0. No partial transfer completes.

Test Plan:
- Reset: reset_n=0 with arbitrary inputs -> Y0..Y3=0, Y_valid=0000, rr_ptr=00, in_ready=1 for every S.
- Unicast: S=2, D=4'hA, in_valid=1, Y_ready=0000 -> next cycle Y2=A, Y_valid=0100. Then S=2, D=4'h5 -> in_ready=0 and Y2 stays A. Then Y_ready=0100 in the same cycle -> in_ready=1 and next cycle Y2=5, Y_valid=0100.
- Drain without load: Y_valid=0011, Y_ready=0001, in_valid=0 -> next cycle Y_valid=0010, Y0 data unchanged.
- Round-robin wrap: rr_mode=1, Y_ready=1111, D=1,2,3,4,5 on consecutive cycles -> Y0=1, Y1=2, Y2=3, Y3=4, then Y0=5; rr_ptr sequence 0,1,2,3,0,1.
- Round-robin stall: rr_mode=1, rr_ptr=1, Y_valid[1]=1, Y_ready=0000, in_valid=1 -> in_ready=0, rr_ptr stays 1, no channel changes. Switch rr_mode=0 with S=3 -> word accepted into Y3, rr_ptr still 1.
- Async reset mid-stream: pulse reset_n low between edges while Y_valid=1111 -> outputs zero immediately without waiting for clk; first accept after release goes to Y[S] (or Y0 if rr_mode=1).
